// File: rtl/rv32_fetch_unit.sv
// rv32_fetch_unit: decoupled RV32 instruction-fetch front end.
// Owns the fetch PC, issues in-order requests to a variable-latency imem,
// buffers responses in a DEPTH-entry prefetch FIFO and hands {instr, pc, pc+4}
// to decode. Redirects from execute flush the FIFO and drop wrong-path responses.
// Optional feature: define FETCH_PERF_CNT_EN to add perf_fetch_cnt/perf_flush_cnt.
module rv32_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d;
    logic [PW-1:0]   fifo_wr_q, fifo_wr_d;
    logic [PW-1:0]   fifo_rd_q, fifo_rd_d;

    // PC tags of outstanding requests, oldest at tag_rd_q; entries == inflight.
    logic [XLEN-1:0] tag_mem   [DEPTH];
    // Prefetch FIFO payload.
    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];

    logic            req_fire;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic [CW:0]     credit_used;
    logic            unused_redirect_bits;

    // Redirect targets are forced word-aligned, so the low bits are ignored.
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // Outstanding requests plus buffered entries may never exceed DEPTH, which
    // guarantees every response has a FIFO slot waiting for it.
    assign credit_used    = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req_valid = (state_q != BOOT) && !redirect_valid && (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_take = imem_rsp_valid && (inflight_q != '0);
    assign push     = rsp_take && (drop_q == '0) && !redirect_valid;

    assign dec_valid = (count_q != '0) && !redirect_valid;
    assign pop       = dec_valid && dec_ready;
    assign dec_instr = instr_mem[fifo_rd_q];
    assign dec_pc    = pc_mem[fifo_rd_q];
    assign dec_pc4   = pc_mem[fifo_rd_q] + XLEN'(4);

    // Next-state logic: redirect wins over every other event in the cycle.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);
        drop_d     = drop_q;
        count_d    = count_q;
        tag_wr_d   = tag_wr_q + PW'(req_fire);
        tag_rd_d   = tag_rd_q + PW'(rsp_take);
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            // Everything still outstanding after this cycle's response is wrong-path.
            drop_d     = inflight_q - CW'(rsp_take);
            count_d    = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_take && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            count_d   = count_q + CW'(push) - CW'(pop);
            fifo_wr_d = fifo_wr_q + PW'(push);
            fifo_rd_d = fifo_rd_q + PW'(pop);
        end

        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (drop_d != '0) begin
            state_d = DRAIN;
        end else begin
            state_d = RUN;
        end
    end

    // Control registers; an asynchronous reset clears all fetch bookkeeping at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_VECTOR;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
        end
    end

    // Storage arrays need no reset: occupancy is tracked by the pointers and counters.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            instr_mem[fifo_wr_q] <= imem_rsp_data;
            pc_mem[fifo_wr_q]    <= tag_mem[tag_rd_q];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;

    // Saturating event counters for issued requests and redirects.
    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (req_fire && (perf_fetch_cnt_q != 32'hFFFF_FFFF)) begin
            perf_fetch_cnt_d = perf_fetch_cnt_q + 32'd1;
        end
        if (redirect_valid && (perf_flush_cnt_q != 32'hFFFF_FFFF)) begin
            perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// tb_rv32_fetch_unit: self-checking bench for rv32_fetch_unit.
// The bench plays the instruction memory (in-order, programmable latency) and
// keeps a queue-level model of outstanding requests and buffered instructions.
// The DUT uses RESET_VECTOR = 32'hFFFF_FFF8 so the PC wrap is exercised from reset.
module tb_rv32_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc4;

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int lat       = 1;
    int req_count = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    // Requests accepted by the imem and not yet answered (wrong-path ones marked stale).
    req_t        imq[$];
    // Instructions the front end should be holding for decode, oldest first.
    logic [31:0] bq[$];
    logic [31:0] exp_req_pc = RV;
    bit          boot       = 1'b1;

    rv32_fetch_unit #(
        .XLEN         (32),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc4        (dec_pc4)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Instruction word the imem returns for a given address.
    function automatic logic [31:0] instrOf(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive all inputs just after a rising edge and hold them until the next call.
    task automatic applyStimulus(input logic rst_v, input logic redir, input logic [31:0] rpc,
                                 input logic drdy, input logic rrdy);
        @(posedge clk);
        #1;
        rst            = rst_v;
        redirect_valid = redir;
        redirect_pc    = rpc;
        dec_ready      = drdy;
        imem_req_ready = rrdy;
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the next decode handshake and pin its PC fields to literals.
    task automatic waitPop(input string name, input logic [31:0] pc, input logic [31:0] pc4, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (dec_valid && dec_ready) begin
                seen = 1'b1;
                checkOutput({name, "_pc"}, dec_pc, pc);
                checkOutput({name, "_pc4"}, dec_pc4, pc4);
            end
        end
        checkOutput({name, "_seen"}, 32'(seen), 32'd1);
    endtask

    // Instruction memory: answers the oldest request once its latency has elapsed.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst && (imq.size() > 0) && (imq[0].due <= cyc)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instrOf(imq[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end
        end
    end

    // Compare process: every cycle, check outputs against the model, then advance
    // the model with the events that take effect on the coming rising edge.
    initial begin
        req_t e;
        bit   exp_req_valid;
        bit   exp_dec_valid;
        forever begin
            @(negedge clk);
            if (!rst) begin
                checkOutput("rst_hold_req_valid", 32'(imem_req_valid), 32'd0);
                checkOutput("rst_hold_dec_valid", 32'(dec_valid), 32'd0);
                imq.delete();
                bq.delete();
                boot       = 1'b1;
                exp_req_pc = RV;
                continue;
            end
            exp_req_valid = !boot && !redirect_valid && ((imq.size() + bq.size()) < DEPTH);
            exp_dec_valid = (bq.size() > 0) && !redirect_valid;
            checkOutput("req_valid", 32'(imem_req_valid), 32'(exp_req_valid));
            checkOutput("dec_valid", 32'(dec_valid), 32'(exp_dec_valid));
            if (exp_dec_valid) begin
                checkOutput("dec_pc", dec_pc, bq[0]);
                checkOutput("dec_instr", dec_instr, instrOf(bq[0]));
                checkOutput("dec_pc4", dec_pc4, bq[0] + 32'd4);
            end
            if (exp_dec_valid && dec_ready) begin
                void'(bq.pop_front());
            end
            if (imem_rsp_valid && (imq.size() > 0)) begin
                e = imq.pop_front();
                if (!e.stale && !redirect_valid) begin
                    bq.push_back(e.addr);
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                checkOutput("req_addr", imem_req_addr, exp_req_pc);
                e.addr  = imem_req_addr;
                e.due   = cyc + lat;
                e.stale = 1'b0;
                imq.push_back(e);
                exp_req_pc = exp_req_pc + 32'd4;
                req_count++;
            end
            if (redirect_valid) begin
                bq.delete();
                foreach (imq[i]) imq[i].stale = 1'b1;
                exp_req_pc = {redirect_pc[31:2], 2'b00};
            end
            boot = 1'b0;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int base;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        imem_req_ready = 1'b0;
        lat            = 1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("reset_dec_valid", 32'(dec_valid), 32'd0);

        // Streaming at latency 1 across the 2^32 wrap, then back-pressure on both sides.
        $display("[TB] scenario: stream from reset vector");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        waitPop("t1_pop0", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 10);
        waitPop("t1_pop1", 32'hFFFF_FFFC, 32'h0000_0000, 1);
        waitPop("t1_pop2", 32'h0000_0000, 32'h0000_0004, 1);
        waitPop("t1_pop3", 32'h0000_0004, 32'h0000_0008, 1);
        runCycles(6);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        runCycles(3);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        runCycles(3);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        runCycles(6);

        // Decode stalled at latency 3: exactly DEPTH requests after a fresh start.
        $display("[TB] scenario: credit limit with decode stalled");
        lat = 3;
        applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b1);
        base = req_count;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        runCycles(20);
        checkOutput("t2_issued", 32'(req_count - base), 32'd4);
        checkOutput("t2_req_blocked", 32'(imem_req_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        waitPop("t2_pop0", 32'h40, 32'h44, 5);
        runCycles(10);

        // Redirect with requests in flight: stale responses must be dropped.
        $display("[TB] scenario: redirect with requests in flight");
        applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        waitPop("t3_pop0", 32'h100, 32'h104, 20);
        waitPop("t3_pop1", 32'h104, 32'h108, 10);
        runCycles(5);

        // Back-to-back redirects while responses keep arriving: last target wins.
        $display("[TB] scenario: back-to-back redirects");
        lat = 2;
        runCycles(5);
        applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        waitPop("t4_pop0", 32'h300, 32'h304, 20);
        waitPop("t4_pop1", 32'h304, 32'h308, 10);
        runCycles(8);

        // Misaligned redirect target, then asynchronous reset mid-stream.
        $display("[TB] scenario: misaligned redirect and async reset");
        lat = 1;
        applyStimulus(1'b1, 1'b1, 32'h103, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        waitPop("t6_pop0", 32'h100, 32'h104, 10);
        runCycles(3);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("t6_async_dec_valid", 32'(dec_valid), 32'd0);
        checkOutput("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
        runCycles(2);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        waitPop("t6_restart0", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 10);
        waitPop("t6_restart1", 32'hFFFF_FFFC, 32'h0000_0000, 1);
        runCycles(4);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
